muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; legal values are even and at least 8.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 Start  input  1  request a new operation; sampled only while Ready=1.
REQ-005 Op  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 A  input  WIDTH  operand 1 (multiplicand / dividend).
REQ-007 B  input  WIDTH  operand 2 (multiplier / divisor).
REQ-008 Ready  output  1  high only in IDLE; block will accept Start.
REQ-009 Busy  output  1  high only in RUN.
REQ-010 Done  output  1  one-cycle pulse; Result is valid.
REQ-011 Result  output  WIDTH  result of the last completed operation.
REQ-012 DivZero  output  1  last completed operation was DIV/DIVU/REM/REMU with B=0.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE; Ready=(IDLE), Busy=(RUN), Done=(DONE).
REQ-014 IDLE with Start=1: latch Op, A and B at that edge (E0); the block then goes to RUN, or to DONE on the fast path (REQ-019).
REQ-015 RUN SHALL perform one iteration per edge, using shift-add for multiply and restoring division for divide, with an internal step counter.
REQ-016 RUN SHALL last exactly WIDTH cycles; Done is high in the cycle following edge E0+WIDTH.
REQ-017 DONE SHALL last exactly one cycle, then return unconditionally to IDLE; Start is ignored in RUN and DONE.
REQ-018 Operand changes after E0 SHALL NOT affect the operation in flight.
REQ-019 Fast path: for divide ops with B=0, or for DIV/REM with A=MIN_SIGNED and B=all-ones, go IDLE->DONE at E0; Done is high in the cycle after E0.
REQ-020 Divide by zero SHALL give: DIV/DIVU Result = all-ones; REM/REMU Result = A; DivZero=1.
REQ-021 Signed overflow SHALL give: DIV Result = MIN_SIGNED; REM Result = 0; DivZero=0.
REQ-022 MUL SHALL return the low WIDTH bits of the 2*WIDTH product; MULH, MULHSU and MULHU return the high WIDTH bits.
REQ-023 Product signedness SHALL be: MULH signed x signed; MULHSU signed A x unsigned B; MULHU unsigned x unsigned.
REQ-024 Signed ops SHALL compute on magnitudes, then apply signs: quotient sign = sign(A) XOR sign(B); remainder sign = sign(A) (truncating division).
REQ-025 Result and DivZero SHALL update only on entry to DONE and hold until the next entry to DONE.
REQ-026 Start asserted in the same cycle DONE returns to IDLE is not accepted; it is accepted at the following edge if still high.

Reset
REQ-027 reset=1 SHALL immediately (asynchronously) force IDLE and set Ready=1, Busy=0, Done=0, Result=0, DivZero=0; the step counter and operand registers clear to 0.
REQ-028 Reset asserted during RUN or DONE SHALL abort the operation with no Done pulse; the first Start after reset deasserts is accepted normally.

Verification (WIDTH=32)
REQ-029 MUL A=10, B=5 -> Done in the cycle after E0+32, Result=50, DivZero=0; Busy high for exactly 32 cycles.
REQ-030 MULH A=0xFFFFFFFF (-1), B=2 -> Result=0xFFFFFFFF; MULHU with the same operands -> Result=0x00000001; MULHSU A=-1, B=0xFFFFFFFF -> Result=0xFFFFFFFF.
REQ-031 DIV A=-7, B=2 -> Result=0xFFFFFFFD (-3); REM with the same operands -> Result=0xFFFFFFFF (-1); DIVU A=10, B=5 -> Result=2.
REQ-032 DIVU A=10, B=0 -> Done in the cycle after E0, Result=0xFFFFFFFF, DivZero=1; REMU A=10, B=0 -> Result=10.
REQ-033 DIV A=0x80000000, B=0xFFFFFFFF -> fast path, Result=0x80000000; REM with the same operands -> Result=0.
REQ-034 Start during RUN with new operands -> ignored, and the original result is returned; reset pulsed mid-RUN -> no Done, all outputs at reset values, and the next MUL 3x4 gives Result=12.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// master drives the operation request; slave (the unit) returns status and result.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [2:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Ready;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Result;
    logic             DivZero;

    modport master (
        output Start, Op, A, B,
        input  Ready, Busy, Done, Result, DivZero
    );

    modport slave (
        input  Start, Op, A, B,
        output Ready, Busy, Done, Result, DivZero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RISC-V style MUL/MULH*/DIV*/REM* unit: one shift-add or restoring step per cycle.
// WIDTH cycles in RUN (fast path straight to DONE for /0 and signed overflow); Start only taken when Ready.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    LAST  = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_S = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO  = {WIDTH{1'b0}};

    logic [1:0]       r_state;
    logic [2:0]       r_op;
    logic             r_sa;
    logic             r_sb;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opb;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_divzero;

    // Operand decode on the request, used only at the accepting edge.
    logic             w_is_div;
    logic             w_a_sgn;
    logic             w_b_sgn;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_div0;
    logic             w_ovf;
    logic [WIDTH-1:0] w_fast_res;

    assign w_is_div   = bus.Op[2];
    assign w_a_sgn    = w_is_div ? ~bus.Op[0] : (bus.Op[1:0] == 2'b01 || bus.Op[1:0] == 2'b10);
    assign w_b_sgn    = w_is_div ? ~bus.Op[0] : (bus.Op[1:0] == 2'b01);
    assign w_a_mag    = (w_a_sgn && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign w_b_mag    = (w_b_sgn && bus.B[WIDTH-1]) ? -bus.B : bus.B;
    assign w_div0     = w_is_div && (bus.B == ZERO);
    assign w_ovf      = w_is_div && !bus.Op[0] && (bus.A == MIN_S) && (bus.B == ONES);
    assign w_fast_res = w_div0 ? (bus.Op[1] ? bus.A : ONES) : (bus.Op[1] ? ZERO : MIN_S);

    // Shift-add step: {r_hi, r_lo} is the partial product, r_lo's LSB selects the add.
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_mhi;
    logic [WIDTH-1:0] w_mlo;

    assign w_sum = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opb : ZERO)};
    assign w_mhi = w_sum[WIDTH:1];
    assign w_mlo = {w_sum[0], r_lo[WIDTH-1:1]};

    // Restoring step: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_dhi;
    logic [WIDTH-1:0] w_dlo;

    assign w_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_opb});
    assign w_diff  = w_shift[WIDTH-1:0] - r_opb;
    assign w_dhi   = w_ge ? w_diff : w_shift[WIDTH-1:0];
    assign w_dlo   = {r_lo[WIDTH-2:0], w_ge};

    logic [WIDTH-1:0] w_nhi;
    logic [WIDTH-1:0] w_nlo;

    assign w_nhi = r_op[2] ? w_dhi : w_mhi;
    assign w_nlo = r_op[2] ? w_dlo : w_mlo;

    // Sign fix-up applied to the magnitude result of the final step.
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
    logic               w_pneg;
    logic               w_qneg;
    logic               w_rneg;
    logic [WIDTH-1:0]   w_mul_res;
    logic [WIDTH-1:0]   w_div_res;
    logic [WIDTH-1:0]   w_final;

    assign w_prod    = {w_nhi, w_nlo};
    assign w_pneg    = (r_op[1:0] == 2'b01) ? (r_sa ^ r_sb) :
                       (r_op[1:0] == 2'b10) ? r_sa : 1'b0;
    assign w_prod_s  = w_pneg ? -w_prod : w_prod;
    assign w_mul_res = (r_op[1:0] == 2'b00) ? w_prod_s[WIDTH-1:0] : w_prod_s[2*WIDTH-1:WIDTH];
    assign w_qneg    = !r_op[0] && (r_sa ^ r_sb);
    assign w_rneg    = !r_op[0] && r_sa;
    assign w_div_res = r_op[1] ? (w_rneg ? -w_nhi : w_nhi) : (w_qneg ? -w_nlo : w_nlo);
    assign w_final   = r_op[2] ? w_div_res : w_mul_res;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_op      <= 3'b000;
            r_sa      <= 1'b0;
            r_sb      <= 1'b0;
            r_hi      <= ZERO;
            r_lo      <= ZERO;
            r_opb     <= ZERO;
            r_cnt     <= '0;
            r_result  <= ZERO;
            r_divzero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.Start) begin
                        r_op  <= bus.Op;
                        r_sa  <= bus.A[WIDTH-1];
                        r_sb  <= bus.B[WIDTH-1];
                        r_cnt <= '0;
                        if (w_div0 || w_ovf) begin
                            r_result  <= w_fast_res;
                            r_divzero <= w_div0;
                            r_state   <= S_DONE;
                        end else begin
                            r_hi    <= ZERO;
                            r_lo    <= w_is_div ? w_a_mag : w_b_mag;
                            r_opb   <= w_is_div ? w_b_mag : w_a_mag;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_hi  <= w_nhi;
                    r_lo  <= w_nlo;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_result  <= w_final;
                        r_divzero <= 1'b0;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.Ready   = (r_state == S_IDLE);
    assign bus.Busy    = (r_state == S_RUN);
    assign bus.Done    = (r_state == S_DONE);
    assign bus.Result  = r_result;
    assign bus.DivZero = r_divzero;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit (WIDTH=32): directed vector table, random ops against a behavioural model,
// and hand sequences for Start-while-busy, Start held through DONE, and reset mid-RUN.
module tb_muldiv_unit;
    localparam int W = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         dz;
        bit           fast;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         dz;
        int           lat;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[19];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, output logic dz);
        logic [2*W-1:0] p;
        logic [W-1:0]   r;
        dz = 1'b0;
        r  = '0;
        case (op)
            3'b000: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; r = p[W-1:0]; end
            3'b001: begin p = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b}; r = p[2*W-1:W]; end
            3'b010: begin p = {{W{a[W-1]}}, a} * {{W{1'b0}}, b}; r = p[2*W-1:W]; end
            3'b011: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; r = p[2*W-1:W]; end
            default: begin
                if (b == '0) begin
                    dz = 1'b1;
                    r  = op[1] ? a : '1;
                end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r = op[1] ? 32'h0 : 32'h8000_0000;
                end else if (op[0]) begin
                    r = op[1] ? (a % b) : (a / b);
                end else begin
                    r = op[1] ? W'($signed(a) % $signed(b)) : W'($signed(a) / $signed(b));
                end
            end
        endcase
        return r;
    endfunction

    // Drive a request at a falling edge, accept it at the next rising edge, then push the expectation.
    task automatic start_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] res, input logic dz, input int lat, input bit push);
        int n = 0;
        exp_t e;
        @(negedge clk);
        while (!bus.Ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            errors++;
            checks++;
            $display("FAIL ready_timeout: Ready stayed 0 for %0d cycles, required 1", n);
        end
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        if (push) begin
            e.res = res;
            e.dz  = dz;
            e.lat = lat;
            exp_q.push_back(e);
        end
    endtask

    // k counts rising edges after the accepting edge before Done is seen.
    task automatic wait_done(input string tag);
        int   k    = 0;
        int   busy = 0;
        exp_t e;
        @(negedge clk);
        while (!bus.Done && k < 200) begin
            if (bus.Busy) busy++;
            @(negedge clk);
            k++;
        end
        if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL %s_sb: Done seen with %0d expected entries, required 1", tag, exp_q.size());
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_latency"}, W'(k), W'(e.lat));
        check({tag, "_busy_cycles"}, W'(busy), (e.lat == 0) ? W'(0) : W'(W));
        check({tag, "_result"}, bus.Result, e.res);
        check({tag, "_divzero"}, W'(bus.DivZero), W'(e.dz));
        @(negedge clk);
        check({tag, "_done_pulse"}, W'({bus.Done, bus.Ready}), W'(2'b01));
        check({tag, "_result_hold"}, bus.Result, e.res);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [W-1:0] ra, rb, rr;
        logic [2:0]   rop;
        logic         rdz;
        int           dones;

        vecs[0]  = '{3'b000, 32'd10,         32'd5,          32'd50,         1'b0, 1'b0};
        vecs[1]  = '{3'b001, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  1'b0, 1'b0};
        vecs[2]  = '{3'b011, 32'hFFFF_FFFF,  32'd2,          32'h0000_0001,  1'b0, 1'b0};
        vecs[3]  = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 1'b0};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, 1'b0};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0, 1'b0};
        vecs[6]  = '{3'b101, 32'd10,         32'd5,          32'd2,          1'b0, 1'b0};
        vecs[7]  = '{3'b101, 32'd10,         32'd0,          32'hFFFF_FFFF,  1'b1, 1'b1};
        vecs[8]  = '{3'b111, 32'd10,         32'd0,          32'd10,         1'b1, 1'b1};
        vecs[9]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 1'b1};
        vecs[10] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000,  1'b0, 1'b1};
        vecs[11] = '{3'b000, 32'hFFFF_FFFD,  32'd7,          32'hFFFF_FFEB,  1'b0, 1'b0};
        vecs[12] = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b0, 1'b0};
        vecs[13] = '{3'b110, 32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0, 1'b0};
        vecs[14] = '{3'b100, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0, 1'b0};
        vecs[15] = '{3'b100, 32'h8000_0000,  32'd1,          32'h8000_0000,  1'b0, 1'b0};
        vecs[16] = '{3'b110, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1'b1, 1'b1};
        vecs[17] = '{3'b001, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  1'b0, 1'b0};
        vecs[18] = '{3'b100, 32'd0,          32'd0,          32'hFFFF_FFFF,  1'b1, 1'b1};

        bus.Start = 1'b0;
        bus.Op    = 3'b000;
        bus.A     = '0;
        bus.B     = '0;

        #2;
        check("reset_ready",   W'(bus.Ready),   W'(1));
        check("reset_busy",    W'(bus.Busy),    W'(0));
        check("reset_done",    W'(bus.Done),    W'(0));
        check("reset_result",  bus.Result,      W'(0));
        check("reset_divzero", W'(bus.DivZero), W'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].dz,
                     vecs[i].fast ? 0 : W, 1'b1);
            wait_done($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 16; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = (i % 4 == 0) ? W'($urandom_range(1, 300)) : $urandom;
            rr  = model(rop, ra, rb, rdz);
            start_op(rop, ra, rb, rr, rdz, (rdz || (rop[2] && !rop[0] && ra == 32'h8000_0000 && rb == '1)) ? 0 : W, 1'b1);
            wait_done($sformatf("rnd%0d_op%0d", i, rop));
        end

        // New request and operands held high throughout RUN and DONE: the first op must be
        // unaffected, DONE must not take the request, and IDLE takes it on the following edge.
        start_op(3'b000, 32'd10, 32'd5, 32'd50, 1'b0, W, 1'b1);
        bus.Start = 1'b1;
        bus.Op    = 3'b101;
        bus.A     = 32'd7;
        bus.B     = 32'd0;
        wait_done("busy_start");
        begin
            exp_t e;
            e.res = 32'hFFFF_FFFF;
            e.dz  = 1'b1;
            e.lat = 0;
            exp_q.push_back(e);
        end
        wait_done("held_start");
        bus.Start = 1'b0;

        // Reset in the middle of RUN: immediate reset values, then no Done at all.
        start_op(3'b000, 32'd7, 32'd9, 32'd0, 1'b0, W, 1'b0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrun_ready",   W'(bus.Ready),   W'(1));
        check("midrun_busy",    W'(bus.Busy),    W'(0));
        check("midrun_done",    W'(bus.Done),    W'(0));
        check("midrun_result",  bus.Result,      W'(0));
        check("midrun_divzero", W'(bus.DivZero), W'(0));
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.Done) dones++;
        end
        check("midrun_no_done", W'(dones), W'(0));
        start_op(3'b000, 32'd3, 32'd4, 32'd12, 1'b0, W, 1'b1);
        wait_done("after_reset");

        check("sb_empty", W'(exp_q.size()), W'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
